gps_iq_collector: RTL and testbench
===================================

// Module: gps_iq_collector
// PURPOSE
//  Receive end of the per-channel serial IQ readout. Each GPS demod channel exposes a serial
//  data bit and takes a shift strobe. This block drives the strobe of one selected channel.
//  It captures the 6*GPS_INTEG_BITS accumulator snapshot, MSB first, in order ip,qp,ie,qe,il,ql.
//  It packs the bits into 16-bit words and queues them in a FIFO for the embedded CPU.
// PARAMETERS
//  GPS_CHANS       12  number of demod channels attached
//  GPS_INTEG_BITS  18  width of each IQ accumulator; snapshot = 6*GPS_INTEG_BITS bits
//  FIFO_DEPTH      8   output word FIFO depth, power of 2, >= 2
// PORTS
//  clk       in   1                one clock
//  rst_n     in   1                asynchronous active-low reset
//  start     in   1                1-cycle request to collect one channel snapshot
//  chan      in   $clog2(GPS_CHANS) channel index, sampled with start
//  ch_sout   in   GPS_CHANS        serial data from each channel, registered at source
//  ch_epoch  in   GPS_CHANS        each channel's snapshot-reload pulse
//  ch_shift  out  GPS_CHANS        shift strobes, at most one bit high
//  busy      out  1                collection in progress
//  done      out  1                1-cycle pulse when the last word is written to the FIFO
//  torn      out  1                selected channel reloaded during collection; sticky
//  rd_data   out  16               FIFO head word
//  rd_valid  out  1                FIFO not empty
//  rd_ready  in   1                CPU pops the head word when rd_valid&rd_ready
// BEHAVIOUR
//  Reset:
//  - busy, done, torn, ch_shift and rd_valid are 0; rd_data is 0.
//  - FIFO is empty and the FSM is in IDLE.
//  - Reset mid-collection abandons it. The source channel is left part-shifted.
//  - The CPU must wait for the next epoch reload before collecting that channel again.
//  Sizes:
//  - NBITS = 6*GPS_INTEG_BITS.
//  - NWORDS = ceil(NBITS/16). The last word is left-justified and zero-padded in its LSBs.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE:
//  - start && chan<GPS_CHANS: latch chan, clear bit/word counters, clear torn, go to SHIFT.
//  - busy is high from the next cycle.
//  - start with chan>=GPS_CHANS is ignored; the FSM stays in IDLE.
//  - start while busy is ignored.
//  SHIFT, per cycle:
//  - If the registered FIFO full flag is 0: sample ch_sout[chan] into the word register.
//    Assert ch_shift[chan] in the same cycle, so the source advances at that edge. Count 1 bit.
//  - If the FIFO is full: ch_shift = 0 and nothing is sampled (stall). The source holds its data.
//  - When the 16th bit of a word, or bit NBITS, is sampled, the completed word (padded if
//    needed) is written to the FIFO at that same clock edge.
//  - After bit NBITS: go to DONE. ch_shift has then been asserted exactly NBITS times.
//  DONE: done=1 for one cycle, busy=0, return to IDLE. A new start is accepted the following cycle.
//  Timing:
//  - First ch_shift is in the cycle after start.
//  - With no stalls, the first word is readable (rd_valid=1) 17 cycles after start.
//  torn:
//  - Set if ch_epoch[chan] is high in any cycle while busy.
//  - Collection continues regardless; the data is then a mix of two snapshots.
//  - Cleared only by rst_n or by an accepted start.
//  FIFO:
//  - Show-ahead: rd_data is valid whenever rd_valid=1 and stays stable until popped.
//  - A push and a pop in the same cycle are both honoured; the count is unchanged.
//  - The full flag is registered, so a pop in a stall cycle resumes shifting the next cycle.
//  - No overflow is possible. Words persist across collections until popped.
// TESTING
//  1. IB=18, chan=3 with a 108-bit pattern 0xA5...; 1 start, rd_ready=1 -> 7 words MSB-first;
//     word 7 = 12 data bits + 4'b0; ch_shift[3] high exactly 108 cycles; done 110 cycles after start.
//  2. FIFO_DEPTH=8, IB=24 (144 bits, 9 words), rd_ready=0 -> shifting stalls after word 8
//     (128 shifts). Raise rd_ready -> word 9 arrives; total shifts=144; no data lost or duplicated.
//  3. ch_epoch[3] pulses at bit 50 of a collection on chan 3 -> torn=1 through done.
//     Next start -> torn=0.
//  4. start with chan=12 (GPS_CHANS=12) -> busy stays 0, no ch_shift.
//     start re-pulsed while busy -> ignored; exactly NWORDS words are produced.
//  5. rst_n low at bit 40 -> all outputs 0 asynchronously and FIFO empty.
//     After release, a new start collects correctly.
//  6. Random rd_ready with 3 back-to-back collections -> words match the golden model in order.
//     ch_shift never has 2 bits set.

Source files
------------

// File: rtl/gps_iq_collector_if.sv
// CPU-side bundle of the IQ collector: collection request/status plus the word FIFO read port.
// Read handshake: a word transfers on any clock edge where rd_valid && rd_ready; rd_data holds until then.
interface gps_iq_collector_if #(
    parameter int GPS_CHANS = 12
);
    localparam int CW = (GPS_CHANS > 1) ? $clog2(GPS_CHANS) : 1;

    logic          start;
    logic [CW-1:0] chan;
    logic          busy;
    logic          done;
    logic          torn;
    logic [15:0]   rd_data;
    logic          rd_valid;
    logic          rd_ready;

    modport master (
        output start, chan, rd_ready,
        input  busy, done, torn, rd_data, rd_valid
    );

    modport slave (
        input  start, chan, rd_ready,
        output busy, done, torn, rd_data, rd_valid
    );
endinterface

// File: rtl/gps_iq_collector.sv
// Serial IQ snapshot collector: strobes one demod channel, packs its bits MSB-first into
// 16-bit words and queues them in a show-ahead FIFO for the CPU.
module gps_iq_collector #(
    parameter int GPS_CHANS      = 12,
    parameter int GPS_INTEG_BITS = 18,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gps_iq_collector_if.slave    bus,
    input  logic [GPS_CHANS-1:0] ch_sout,
    input  logic [GPS_CHANS-1:0] ch_epoch,
    output logic [GPS_CHANS-1:0] ch_shift,
    output logic [1:0]           fsm_state
);
    localparam int NBITS = 6 * GPS_INTEG_BITS;
    localparam int CW    = (GPS_CHANS > 1) ? $clog2(GPS_CHANS) : 1;
    localparam int BW    = $clog2(NBITS + 1);
    localparam int AW    = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] sel;
    logic [BW-1:0] bit_cnt;
    logic [3:0]    nib;
    logic [15:0]   word_sr;
    logic          torn_r;
    logic          done_r;

    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count, count_next;
    logic          full_r;
    logic          rd_valid;

    logic          accept, shift_en, bit_in, last_bit, push, pop;
    logic [15:0]   word_next, push_data;

    always_comb begin
        accept     = (state == IDLE) && bus.start && (int'(bus.chan) < GPS_CHANS);
        shift_en   = (state == SHIFT) && !full_r;
        bit_in     = ch_sout[sel];
        word_next  = {word_sr[14:0], bit_in};
        last_bit   = (bit_cnt == BW'(NBITS - 1));
        push       = shift_en && ((nib == 4'd15) || last_bit);
        // A short final word is left-justified; shifting also discards stale upper bits.
        push_data  = word_next << (4'd15 - nib);
        pop        = rd_valid && bus.rd_ready;
        count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        ch_shift   = '0;
        if (shift_en) ch_shift[sel] = 1'b1;
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SHIFT;
            SHIFT:   if (shift_en && last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel     <= '0;
            bit_cnt <= '0;
            nib     <= '0;
            word_sr <= '0;
            torn_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state  <= state_next;
            done_r <= (state == DONE);
            if (accept) begin
                sel     <= bus.chan;
                bit_cnt <= '0;
                nib     <= '0;
                torn_r  <= 1'b0;
            end else begin
                if ((state == SHIFT) && ch_epoch[sel]) torn_r <= 1'b1;
                if (shift_en) begin
                    word_sr <= word_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    nib     <= nib + 4'd1;
                end
            end
        end
    end

    // Full flag is registered: shifting is gated by last cycle's occupancy, so no overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            full_r <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count  <= count_next;
            full_r <= (count_next == (AW+1)'(FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= push_data;
    end

    assign rd_valid     = (count != '0);
    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = rd_valid ? mem[rptr] : 16'd0;
    assign bus.busy     = (state == SHIFT);
    assign bus.done     = done_r;
    assign bus.torn     = torn_r;
    assign fsm_state    = state;
endmodule

// File: tb/tb_gps_iq_collector.sv
// Bench for gps_iq_collector: channel shift-register sources, random FIFO drain, and a word
// scoreboard fed from snapshot values packed by plain slicing.
module tb_gps_iq_collector;
    localparam int GPS_CHANS      = 12;
    localparam int GPS_INTEG_BITS = 18;
    localparam int FIFO_DEPTH     = 8;
    localparam int NBITS          = 6 * GPS_INTEG_BITS;
    localparam int NWORDS         = (NBITS + 15) / 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [GPS_CHANS-1:0] ch_sout;
    logic [GPS_CHANS-1:0] ch_epoch = '0;
    logic [GPS_CHANS-1:0] ch_shift;
    logic [1:0]           fsm_state;

    gps_iq_collector_if #(.GPS_CHANS(GPS_CHANS)) bus();

    gps_iq_collector #(
        .GPS_CHANS(GPS_CHANS),
        .GPS_INTEG_BITS(GPS_INTEG_BITS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .ch_sout(ch_sout),
        .ch_epoch(ch_epoch),
        .ch_shift(ch_shift),
        .fsm_state(fsm_state)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rd_mode = 0;
    int done_total = 0;
    int multi_hot = 0;
    int shifts_total[GPS_CHANS] = '{default: 0};
    logic torn_at_done = 1'b0;
    logic [15:0] exp_q[$];
    logic [NBITS-1:0] src_sr[GPS_CHANS];
    logic [NBITS-1:0] snap_next[GPS_CHANS];

    always @(posedge clk) cyc <= cyc + 1;

    // Channel sources: reload on epoch (wins over a shift), otherwise advance on strobe.
    always @(posedge clk) begin
        for (int c = 0; c < GPS_CHANS; c++) begin
            if (ch_epoch[c]) src_sr[c] <= snap_next[c];
            else if (ch_shift[c]) src_sr[c] <= src_sr[c] << 1;
        end
    end

    always_comb begin
        ch_sout = '0;
        for (int c = 0; c < GPS_CHANS; c++) ch_sout[c] = src_sr[c][NBITS-1];
    end

    always @(posedge clk) begin
        #1;
        case (rd_mode)
            0:       bus.rd_ready = 1'b0;
            1:       bus.rd_ready = 1'b1;
            default: bus.rd_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // monitor + scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < GPS_CHANS; c++) if (ch_shift[c]) shifts_total[c]++;
            if ($countones(ch_shift) > 1) multi_hot++;
            if (bus.done) begin
                done_total++;
                torn_at_done = bus.torn;
            end
            if (bus.rd_valid && bus.rd_ready) begin
                check("word_avail", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("word", bus.rd_data, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [NBITS-1:0] snap);
        logic [NWORDS*16-1:0] padded;
        padded = {snap, {(NWORDS*16-NBITS){1'b0}}};
        for (int w = 0; w < NWORDS; w++) exp_q.push_back(padded[NWORDS*16-1-16*w -: 16]);
    endtask

    task automatic load(input int c, input logic [NBITS-1:0] v);
        snap_next[c] = v;
        ch_epoch[c] = 1'b1;
        tick();
        ch_epoch[c] = 1'b0;
    endtask

    task automatic do_start(input int c);
        bus.start = 1'b1;
        bus.chan = 4'(c);
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int base, n;
        base = done_total;
        n = 0;
        while (done_total == base && n < budget) begin
            tick();
            n++;
        end
        check(tag, done_total - base, 1);
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        tick();
        check(tag, exp_q.size(), 0);
        check({tag, "_empty"}, bus.rd_valid, 0);
    endtask

    function automatic logic [NBITS-1:0] rand_snap();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[NBITS-1:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NBITS-1:0] s1, sa, sb, so, sn, mix, s4, s5, s6;
        int s, fv, dc, b, db, n, sum0;
        int chs[3];

        bus.start = 1'b0;
        bus.chan = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_torn", bus.torn, 0);
        check("rst_shift", ch_shift, 0);
        check("rst_valid", bus.rd_valid, 0);
        check("rst_data", bus.rd_data, 0);
        rst_n = 1'b1;
        tick();

        // 1: fixed pattern, free-running drain, latencies
        rd_mode = 1;
        s1 = {{13{8'hA5}}, 4'hA};
        load(3, s1);
        push_expected(s1);
        b = shifts_total[3];
        s = cyc;
        do_start(3);
        check("t1_busy", bus.busy, 1);
        fv = -1;
        dc = -1;
        for (int i = 0; i < 200 && dc < 0; i++) begin
            if (bus.rd_valid && fv < 0) fv = cyc - s;
            if (bus.done) dc = cyc - s;
            tick();
        end
        check("t1_first_word_lat", fv, 17);
        check("t1_done_lat", dc, 110);
        check("t1_shifts", shifts_total[3] - b, NBITS);
        check("t1_idle_busy", bus.busy, 0);
        drain(100, "t1_drain");

        // 2: FIFO full stall and resume
        rd_mode = 0;
        sa = rand_snap();
        load(5, sa);
        push_expected(sa);
        b = shifts_total[5];
        do_start(5);
        wait_done(300, "t2_done_a");
        check("t2_shifts_a", shifts_total[5] - b, NBITS);
        sb = rand_snap();
        load(5, sb);
        push_expected(sb);
        b = shifts_total[5];
        do_start(5);
        repeat (100) tick();
        check("t2_stall_shifts", shifts_total[5] - b, 16);
        check("t2_stall_busy", bus.busy, 1);
        check("t2_stall_valid", bus.rd_valid, 1);
        rd_mode = 2;
        wait_done(3000, "t2_done_b");
        check("t2_shifts_b", shifts_total[5] - b, NBITS);
        drain(3000, "t2_drain");

        // 3: epoch reload mid-collection
        rd_mode = 1;
        so = rand_snap();
        sn = rand_snap();
        load(3, so);
        mix = {so[NBITS-1:57], sn[NBITS-1:51]};
        push_expected(mix);
        b = shifts_total[3];
        do_start(3);
        check("t3_torn_clear", bus.torn, 0);
        n = 0;
        while (shifts_total[3] - b < 50 && n < 200) begin
            tick();
            n++;
        end
        check("t3_reach50", shifts_total[3] - b, 50);
        snap_next[3] = sn;
        ch_epoch[3] = 1'b1;
        tick();
        ch_epoch[3] = 1'b0;
        check("t3_torn_set", bus.torn, 1);
        wait_done(200, "t3_done");
        check("t3_torn_at_done", torn_at_done, 1);
        drain(100, "t3_drain");
        check("t3_torn_sticky", bus.torn, 1);

        // 4: out-of-range channel, start while busy
        sum0 = 0;
        for (int c = 0; c < GPS_CHANS; c++) sum0 += shifts_total[c];
        db = done_total;
        do_start(12);
        check("t4_bad_busy", bus.busy, 0);
        repeat (20) tick();
        n = 0;
        for (int c = 0; c < GPS_CHANS; c++) n += shifts_total[c];
        check("t4_bad_shifts", n - sum0, 0);
        check("t4_bad_done", done_total - db, 0);
        check("t4_bad_torn_kept", bus.torn, 1);
        s4 = rand_snap();
        load(3, s4);
        push_expected(s4);
        do_start(3);
        check("t4_torn_cleared", bus.torn, 0);
        repeat (5) tick();
        do_start(3);
        wait_done(300, "t4_done");
        repeat (10) tick();
        check("t4_single_done", done_total - db, 1);
        drain(100, "t4_drain");

        // 5: asynchronous reset mid-collection
        s5 = rand_snap();
        load(7, s5);
        push_expected(s5);
        b = shifts_total[7];
        do_start(7);
        n = 0;
        while (shifts_total[7] - b < 40 && n < 200) begin
            tick();
            n++;
        end
        check("t5_reach40", shifts_total[7] - b, 40);
        #1;
        rst_n = 1'b0;
        #1;
        check("t5_busy", bus.busy, 0);
        check("t5_done", bus.done, 0);
        check("t5_torn", bus.torn, 0);
        check("t5_shift", ch_shift, 0);
        check("t5_valid", bus.rd_valid, 0);
        check("t5_data", bus.rd_data, 0);
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        s6 = rand_snap();
        load(7, s6);
        push_expected(s6);
        b = shifts_total[7];
        do_start(7);
        wait_done(300, "t5_done_after");
        check("t5_shifts_after", shifts_total[7] - b, NBITS);
        drain(100, "t5_drain");

        // 6: back-to-back collections with random drain
        rd_mode = 2;
        chs = '{0, 7, 11};
        for (int k = 0; k < 3; k++) begin
            s = 0;
            sa = rand_snap();
            load(chs[k], sa);
            push_expected(sa);
        end
        for (int k = 0; k < 3; k++) begin
            b = shifts_total[chs[k]];
            do_start(chs[k]);
            wait_done(3000, "t6_done");
            check("t6_shifts", shifts_total[chs[k]] - b, NBITS);
        end
        drain(3000, "t6_drain");

        check("onehot_shift", multi_hot, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
